fifo_mbox: RTL and testbench
============================

FIFO_MBOX -- requirements
Module: fifo_mbox

Interface
REQ-001 SHALL have parameter DW, default 8: data width in bits.
REQ-002 SHALL have parameter AW, default 11: address width; depth = 2^AW entries.
REQ-003 SHALL have parameter EDGE_MODE, default 1: 1 = commit on strobe deassertion (bus-strobe mode), 0 = commit on single-cycle strobe (pulse mode).
REQ-004 SHALL have parameter AF_LVL, default 2^AW-16: almost-full threshold.
REQ-005 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port di  input  DW  write data.
REQ-008 SHALL have port we  input  1  write strobe.
REQ-009 SHALL have port oe  input  1  read strobe.
REQ-010 SHALL have port flush  input  1  synchronous empty-all.
REQ-011 SHALL have port clr_err  input  1  clears the sticky error flags.
REQ-012 SHALL have port dato  output  DW  head-of-queue data, registered.
REQ-013 SHALL have port empty  output  1  level == 0.
REQ-014 SHALL have port full  output  1  level == 2^AW.
REQ-015 SHALL have port almost_full  output  1  level >= AF_LVL.
REQ-016 SHALL have port level  output  AW+1  current occupancy.
REQ-017 SHALL have port ovf  output  1  sticky: push rejected.
REQ-018 SHALL have port udf  output  1  sticky: pop rejected.

Function
REQ-019 SHALL keep wr_ptr and rd_ptr as AW+1-bit counters; addresses are ptr[AW-1:0]; wrap is modulo 2^(AW+1); level = wr_ptr - rd_ptr.
REQ-020 In EDGE_MODE=1, SHALL record we and oe each cycle in 2-bit histories; push_commit = history 2'b10 (deassertion seen one cycle late); pop_commit likewise.
REQ-021 In EDGE_MODE=1, storage SHALL be written at wr_ptr every cycle that we=1 and full=0; the last written di before deassertion is the committed value.
REQ-022 In EDGE_MODE=0, push_commit = we and pop_commit = oe in the same cycle; storage written on that cycle when full=0.
REQ-023 Accepted push SHALL increment wr_ptr on the commit cycle; accepted pop SHALL increment rd_ptr on the commit cycle; flags update the following cycle.
REQ-024 push_commit while full SHALL be rejected and set ovf, even if pop_commit occurs in the same cycle.
REQ-025 pop_commit while empty SHALL be rejected and set udf, even if push_commit occurs in the same cycle.
REQ-026 Simultaneous accepted push and pop SHALL leave level unchanged.
REQ-027 dato SHALL be registered storage read at rd_ptr; valid one cycle after any change of rd_ptr or of the head entry; undefined content is permitted while empty=1.
REQ-028 flush=1 SHALL set wr_ptr=rd_ptr=0 and clear strobe histories next cycle; flush has priority over all commits; ovf/udf are unaffected.
REQ-029 clr_err=1 SHALL clear ovf and udf; a set event in the same cycle wins.

Reset
REQ-030 rst_n=0 SHALL asynchronously force wr_ptr=rd_ptr=0, histories=0, dato=0, ovf=udf=0; thus empty=1, full=0, almost_full=0, level=0.
REQ-031 Strobes active during reset release SHALL NOT commit (histories restart from 0, so a we held high through release commits only on its later deassertion).

Structure
REQ-032 SHALL place strobe-history encodings (2'b10 end pattern) and mode constants in shared package fifo_pkg.
REQ-033 SHALL instantiate one sub-module fifo_ram: simple dual-port RAM, DW x 2^AW, write port A, registered read port B, same clk.

Verification
REQ-034 EDGE_MODE=1, push 0x11,0x22,0x33 (we high 3 cycles each) -> level=3; three oe strobes -> dato 0x11,0x22,0x33 in order, empty=1 after.
REQ-035 AW=2, EDGE_MODE=0, push 5 values -> full=1 after 4th, 5th rejected, ovf=1, level=4; clr_err -> ovf=0.
REQ-036 Pop on empty -> udf=1, rd_ptr unchanged; push+pop same cycle on empty -> level=1, udf=1.
REQ-037 AW=2, full, simultaneous push+pop -> level=3, ovf=1, head advances.
REQ-038 Fill 10 entries, assert flush with a pending we strobe -> level=0, empty=1, no commit.
REQ-039 Pulse rst_n low mid-strobe with level=5 -> all outputs at reset values immediately; no commit on release.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared constants for the mailbox FIFO: commit modes and the strobe-history end pattern.
package fifo_pkg;

  localparam int MODE_PULSE = 0;
  localparam int MODE_EDGE  = 1;

  localparam logic [1:0] HIST_IDLE = 2'b00;
  localparam logic [1:0] HIST_END  = 2'b10;

  // High two cycles ago, low last cycle: the strobe has just been released.
  function automatic logic strobe_end(input logic [1:0] hist);
    return (hist == HIST_END);
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port RAM: write port A, registered read port B, single clock.
module fifo_ram #(
  parameter int DW = 8,
  parameter int AW = 11
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_din,
  input  logic [AW-1:0] b_addr,
  output logic [DW-1:0] b_dout
);

  logic [DW-1:0] mem_r [2**AW];
  logic [DW-1:0] b_dout_r;

  // Port A write
  always_ff @(posedge clk) begin
    if (a_we) begin
      mem_r[a_addr] <= a_din;
    end
  end

  // Port B registered read; cleared by reset so the head output starts at zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b_dout_r <= '0;
    end else begin
      b_dout_r <= mem_r[b_addr];
    end
  end

  assign b_dout = b_dout_r;

endmodule

// File: rtl/fifo_mbox.sv
// Mailbox FIFO with pulse or bus-strobe commit, sticky overflow/underflow and registered status.
module fifo_mbox
  import fifo_pkg::*;
#(
  parameter int DW        = 8,
  parameter int AW        = 11,
  parameter int EDGE_MODE = MODE_EDGE,
  parameter int AF_LVL    = 2**AW - 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] di,
  input  logic          we,
  input  logic          oe,
  input  logic          flush,
  input  logic          clr_err,
  output logic [DW-1:0] dato,
  output logic          empty,
  output logic          full,
  output logic          almost_full,
  output logic [AW:0]   level,
  output logic          ovf,
  output logic          udf
);

  localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

  logic [AW:0] wr_ptr_r, rd_ptr_r, level_r;
  logic [AW:0] wr_nxt_s, rd_nxt_s, lvl_nxt_s;
  logic [1:0]  we_hist_r, oe_hist_r;
  logic        empty_r, full_r, af_r, ovf_r, udf_r;
  logic        push_s, pop_s, push_ok_s, pop_ok_s;
  logic        ovf_set_s, udf_set_s, ram_we_s;

  // Commit decode, acceptance and next pointer values
  always_comb begin
    push_s    = 1'b0;
    pop_s     = 1'b0;
    push_ok_s = 1'b0;
    pop_ok_s  = 1'b0;
    ovf_set_s = 1'b0;
    udf_set_s = 1'b0;
    ram_we_s  = 1'b0;
    wr_nxt_s  = wr_ptr_r;
    rd_nxt_s  = rd_ptr_r;
    lvl_nxt_s = level_r;

    if (EDGE_MODE == MODE_EDGE) begin
      push_s = strobe_end(we_hist_r);
      pop_s  = strobe_end(oe_hist_r);
    end else begin
      push_s = we;
      pop_s  = oe;
    end

    // Full/empty are judged on the pre-cycle state, so a same-cycle pop never rescues a push.
    ram_we_s  = we & ~full_r & ~flush;
    push_ok_s = push_s & ~full_r & ~flush;
    pop_ok_s  = pop_s & ~empty_r & ~flush;
    ovf_set_s = push_s & full_r & ~flush;
    udf_set_s = pop_s & empty_r & ~flush;

    if (flush) begin
      wr_nxt_s = '0;
      rd_nxt_s = '0;
    end else begin
      wr_nxt_s = wr_ptr_r + {{AW{1'b0}}, push_ok_s};
      rd_nxt_s = rd_ptr_r + {{AW{1'b0}}, pop_ok_s};
    end
    lvl_nxt_s = wr_nxt_s - rd_nxt_s;
  end

  // Pointers, strobe histories, status flags and sticky errors
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r  <= '0;
      rd_ptr_r  <= '0;
      we_hist_r <= HIST_IDLE;
      oe_hist_r <= HIST_IDLE;
      level_r   <= '0;
      empty_r   <= 1'b1;
      full_r    <= 1'b0;
      af_r      <= 1'b0;
      ovf_r     <= 1'b0;
      udf_r     <= 1'b0;
    end else begin
      wr_ptr_r  <= wr_nxt_s;
      rd_ptr_r  <= rd_nxt_s;
      we_hist_r <= flush ? HIST_IDLE : {we_hist_r[0], we};
      oe_hist_r <= flush ? HIST_IDLE : {oe_hist_r[0], oe};
      level_r   <= lvl_nxt_s;
      empty_r   <= (lvl_nxt_s == '0);
      full_r    <= (lvl_nxt_s == DEPTH);
      af_r      <= (int'(lvl_nxt_s) >= AF_LVL);
      ovf_r     <= ovf_set_s | (ovf_r & ~clr_err);
      udf_r     <= udf_set_s | (udf_r & ~clr_err);
    end
  end

  fifo_ram #(
    .DW(DW),
    .AW(AW)
  ) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .a_we  (ram_we_s),
    .a_addr(wr_ptr_r[AW-1:0]),
    .a_din (di),
    .b_addr(rd_ptr_r[AW-1:0]),
    .b_dout(dato)
  );

  assign empty       = empty_r;
  assign full        = full_r;
  assign almost_full = af_r;
  assign level       = level_r;
  assign ovf         = ovf_r;
  assign udf         = udf_r;

endmodule

// File: tb/tb_fifo_mbox.sv
// Bench: a bus-strobe instance (default geometry) and a 4-deep pulse instance checked against queue models.
module tb_fifo_mbox;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        e_rst_n, e_we, e_oe, e_flush, e_clr;
  logic [7:0]  e_di, e_dato;
  logic        e_empty, e_full, e_af, e_ovf, e_udf;
  logic [11:0] e_level;

  logic        p_rst_n, p_we, p_oe, p_flush, p_clr;
  logic [7:0]  p_di, p_dato;
  logic        p_empty, p_full, p_af, p_ovf, p_udf;
  logic [2:0]  p_level;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] eq[$];
  logic [7:0] pq[$];
  logic [7:0] pv[5];

  fifo_mbox u_edge (
    .clk(clk), .rst_n(e_rst_n), .di(e_di), .we(e_we), .oe(e_oe), .flush(e_flush),
    .clr_err(e_clr), .dato(e_dato), .empty(e_empty), .full(e_full),
    .almost_full(e_af), .level(e_level), .ovf(e_ovf), .udf(e_udf)
  );

  fifo_mbox #(.DW(8), .AW(2), .EDGE_MODE(0), .AF_LVL(3)) u_pulse (
    .clk(clk), .rst_n(p_rst_n), .di(p_di), .we(p_we), .oe(p_oe), .flush(p_flush),
    .clr_err(p_clr), .dato(p_dato), .empty(p_empty), .full(p_full),
    .almost_full(p_af), .level(p_level), .ovf(p_ovf), .udf(p_udf)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Bus-strobe push: di changes while we is high, only the last value counts.
  task automatic e_push(input logic [7:0] v);
    e_we = 1'b1;
    e_di = 8'($urandom);
    tick();
    e_di = 8'($urandom);
    tick();
    e_di = v;
    tick();
    e_we = 1'b0;
    tick();
    chk("e_push_hold", 32'(e_level), 32'(eq.size()));
    tick();
    eq.push_back(v);
    chk("e_push_commit", 32'(e_level), 32'(eq.size()));
    tick();
  endtask

  task automatic e_pop();
    e_oe = 1'b1;
    tick();
    e_oe = 1'b0;
    tick();
    tick();
    if (eq.size() != 0) void'(eq.pop_front());
    chk("e_pop_level", 32'(e_level), 32'(eq.size()));
    tick();
    if (eq.size() != 0) chk("e_pop_head", 32'(e_dato), 32'(eq[0]));
  endtask

  task automatic p_cyc(input logic w, input logic o, input logic [7:0] d);
    p_we = w;
    p_oe = o;
    p_di = d;
    tick();
    p_we = 1'b0;
    p_oe = 1'b0;
  endtask

  initial begin
    logic       w, o, f, c, hv, so, su, m_ovf, m_udf;
    logic [7:0] d, h;

    e_rst_n = 1'b0; e_we = 1'b0; e_oe = 1'b0; e_flush = 1'b0; e_clr = 1'b0; e_di = 8'h00;
    p_rst_n = 1'b0; p_we = 1'b0; p_oe = 1'b0; p_flush = 1'b0; p_clr = 1'b0; p_di = 8'h00;
    tick();
    tick();
    chk("rst_e_level", 32'(e_level), 32'd0);
    chk("rst_e_empty", 32'(e_empty), 32'd1);
    chk("rst_e_full",  32'(e_full),  32'd0);
    chk("rst_e_af",    32'(e_af),    32'd0);
    chk("rst_e_dato",  32'(e_dato),  32'd0);
    chk("rst_p_level", 32'(p_level), 32'd0);
    chk("rst_p_empty", 32'(p_empty), 32'd1);
    chk("rst_p_errs",  32'({p_ovf, p_udf, e_ovf, e_udf}), 32'd0);
    e_rst_n = 1'b1;
    p_rst_n = 1'b1;
    tick();

    // Bus-strobe ordering: three pushes then three pops
    e_push(8'h11);
    e_push(8'h22);
    e_push(8'h33);
    chk("e_three_level", 32'(e_level), 32'd3);
    chk("e_three_head",  32'(e_dato),  32'h11);
    e_pop();
    e_pop();
    e_pop();
    chk("e_drain_empty", 32'(e_empty), 32'd1);
    chk("e_drain_udf",   32'(e_udf),   32'd0);

    // Ten entries, then a commit pending in the flush cycle must be dropped
    for (int i = 0; i < 10; i++) e_push(8'($urandom_range(1, 255)));
    chk("e_ten_level", 32'(e_level), 32'd10);
    chk("e_ten_af",    32'(e_af),    32'd0);
    chk("e_ten_head",  32'(e_dato),  32'(eq[0]));
    e_we = 1'b1;
    e_di = 8'h77;
    tick();
    tick();
    e_we = 1'b0;
    tick();
    e_flush = 1'b1;
    tick();
    e_flush = 1'b0;
    eq.delete();
    chk("e_flush_level", 32'(e_level), 32'd0);
    chk("e_flush_empty", 32'(e_empty), 32'd1);
    tick();
    tick();
    chk("e_flush_nocommit", 32'(e_level), 32'd0);
    e_pop();
    chk("e_udf_set", 32'(e_udf), 32'd1);

    // Asynchronous reset in the middle of a strobe
    for (int i = 0; i < 5; i++) e_push(8'($urandom_range(1, 255)));
    chk("e_five_level", 32'(e_level), 32'd5);
    chk("e_five_head",  32'(e_dato),  32'(eq[0]));
    e_we = 1'b1;
    e_di = 8'hC3;
    tick();
    e_rst_n = 1'b0;
    #1;
    eq.delete();
    chk("e_arst_level", 32'(e_level), 32'd0);
    chk("e_arst_empty", 32'(e_empty), 32'd1);
    chk("e_arst_flags", 32'({e_full, e_af, e_ovf, e_udf}), 32'd0);
    chk("e_arst_dato",  32'(e_dato),  32'd0);
    tick();
    tick();
    e_rst_n = 1'b1;
    e_di = 8'h5A;
    tick();
    tick();
    tick();
    chk("e_release_nocommit", 32'(e_level), 32'd0);
    e_we = 1'b0;
    tick();
    chk("e_release_hold", 32'(e_level), 32'd0);
    tick();
    chk("e_release_commit", 32'(e_level), 32'd1);
    tick();
    chk("e_release_data", 32'(e_dato), 32'h5A);

    // Pulse mode: underflow, and push+pop on empty
    p_cyc(1'b0, 1'b1, 8'h00);
    chk("p_udf_set",   32'(p_udf),   32'd1);
    chk("p_udf_level", 32'(p_level), 32'd0);
    p_clr = 1'b1;
    tick();
    p_clr = 1'b0;
    chk("p_udf_clr", 32'(p_udf), 32'd0);
    p_cyc(1'b1, 1'b1, 8'hA5);
    chk("p_pp_empty_level", 32'(p_level), 32'd1);
    chk("p_pp_empty_udf",   32'(p_udf),   32'd1);
    tick();
    chk("p_pp_empty_data", 32'(p_dato), 32'hA5);
    p_cyc(1'b0, 1'b1, 8'h00);
    chk("p_pop_one", 32'(p_level), 32'd0);
    p_clr = 1'b1;
    tick();
    p_clr = 1'b0;

    // Pulse mode: fill past full
    for (int i = 0; i < 5; i++) begin
      pv[i] = 8'($urandom);
      p_cyc(1'b1, 1'b0, pv[i]);
      chk("p_fill_level", 32'(p_level), 32'((i < 4) ? i + 1 : 4));
      chk("p_fill_full",  32'(p_full),  32'(i >= 3));
      chk("p_fill_af",    32'(p_af),    32'(i >= 2));
      chk("p_fill_ovf",   32'(p_ovf),   32'(i == 4));
    end
    tick();
    chk("p_fill_head", 32'(p_dato), 32'(pv[0]));
    p_clr = 1'b1;
    tick();
    chk("p_ovf_clr", 32'(p_ovf), 32'd0);
    p_we = 1'b1;
    tick();
    p_we = 1'b0;
    p_clr = 1'b0;
    chk("p_set_wins", 32'(p_ovf), 32'd1);
    p_clr = 1'b1;
    tick();
    p_clr = 1'b0;

    // Pulse mode: push+pop while full
    p_cyc(1'b1, 1'b1, 8'hEE);
    chk("p_pp_full_level", 32'(p_level), 32'd3);
    chk("p_pp_full_ovf",   32'(p_ovf),   32'd1);
    tick();
    chk("p_pp_full_head", 32'(p_dato), 32'(pv[1]));

    // Pulse mode: random traffic against a queue model
    p_flush = 1'b1;
    p_clr = 1'b1;
    tick();
    p_flush = 1'b0;
    p_clr = 1'b0;
    pq.delete();
    m_ovf = 1'b0;
    m_udf = 1'b0;
    for (int i = 0; i < 600; i++) begin
      w = 1'($urandom_range(0, 1));
      o = ($urandom_range(0, 2) == 0);
      f = ($urandom_range(0, 31) == 0);
      c = ($urandom_range(0, 15) == 0);
      d = 8'($urandom);
      hv = (pq.size() != 0);
      h  = hv ? pq[0] : 8'h00;
      so = 1'b0;
      su = 1'b0;
      if (f) begin
        pq.delete();
      end else begin
        so = w && (pq.size() == 4);
        su = o && (pq.size() == 0);
        if (o && !su) void'(pq.pop_front());
        if (w && !so) pq.push_back(d);
      end
      m_ovf = so ? 1'b1 : (c ? 1'b0 : m_ovf);
      m_udf = su ? 1'b1 : (c ? 1'b0 : m_udf);
      p_we = w;
      p_oe = o;
      p_flush = f;
      p_clr = c;
      p_di = d;
      tick();
      chk("rnd_level", 32'(p_level), 32'(pq.size()));
      chk("rnd_empty", 32'(p_empty), 32'(pq.size() == 0));
      chk("rnd_full",  32'(p_full),  32'(pq.size() == 4));
      chk("rnd_af",    32'(p_af),    32'(pq.size() >= 3));
      chk("rnd_ovf",   32'(p_ovf),   32'(m_ovf));
      chk("rnd_udf",   32'(p_udf),   32'(m_udf));
      if (hv) chk("rnd_dato", 32'(p_dato), 32'(h));
    end
    p_we = 1'b0;
    p_oe = 1'b0;
    p_flush = 1'b0;
    p_clr = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
